// File: rtl/memory_access.sv
// ---------------------------------------------------------------------------
// memory_access -- MA pipeline stage: issues data-memory requests, encodes
// store lanes, extracts/extends load data, and registers the MA/WB boundary.
//
// Ports:
//   i_clk, i_reset              clock, asynchronous active-low reset
//   i_control_ma_wb             {mem_read, mem_write, size[1:0], unsigned,
//                                mem_to_reg, reg_write}
//   i_result                    ALU result / memory address
//   i_w_data_mem                store data
//   i_rd_num                    destination register
//   o_dmem_req/we/addr/wdata/be data-memory request side
//   i_dmem_ack, i_dmem_rdata    data-memory completion and read word
//   o_stall                     hold upstream stages
//   o_misaligned                one-cycle registered exception pulse
//   o_control_wb, o_read_data,
//   o_alu_result, o_rd_num      registered WB-stage outputs
//   o_ex_rd_data, o_ex_rd_num,
//   o_ex_ctl_rw                 combinational forwarding to EX
// ---------------------------------------------------------------------------
module memory_access #(
    parameter int NB_DATA           = 32,
    parameter int NB_ADDR_REGISTERS = 5,
    parameter int NB_CONTROL_MA     = 5,
    parameter int NB_CONTROL_WB     = 2,
    parameter int NB_CONTROL_MA_WB  = 7
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [NB_CONTROL_MA_WB-1:0]  i_control_ma_wb,
    input  logic [NB_DATA-1:0]           i_result,
    input  logic [NB_DATA-1:0]           i_w_data_mem,
    input  logic [NB_ADDR_REGISTERS-1:0] i_rd_num,
    output logic                         o_dmem_req,
    output logic                         o_dmem_we,
    output logic [NB_DATA-1:0]           o_dmem_addr,
    output logic [NB_DATA-1:0]           o_dmem_wdata,
    output logic [3:0]                   o_dmem_be,
    input  logic                         i_dmem_ack,
    input  logic [NB_DATA-1:0]           i_dmem_rdata,
    output logic                         o_stall,
    output logic                         o_misaligned,
    output logic [NB_CONTROL_WB-1:0]     o_control_wb,
    output logic [NB_DATA-1:0]           o_read_data,
    output logic [NB_DATA-1:0]           o_alu_result,
    output logic [NB_ADDR_REGISTERS-1:0] o_rd_num,
    output logic [NB_DATA-1:0]           o_ex_rd_data,
    output logic [NB_ADDR_REGISTERS-1:0] o_ex_rd_num,
    output logic                         o_ex_ctl_rw
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t state, state_next;

    // Control decode: MA field sits above the WB field.
    logic [NB_CONTROL_MA-1:0] ctl_ma;
    logic [NB_CONTROL_WB-1:0] ctl_wb;
    logic                     mem_read, mem_write, is_unsigned;
    logic [1:0]               size;
    logic                     mem_to_reg, reg_write;

    assign ctl_ma      = i_control_ma_wb[NB_CONTROL_MA_WB-1 -: NB_CONTROL_MA];
    assign ctl_wb      = i_control_ma_wb[NB_CONTROL_WB-1:0];
    assign mem_read    = ctl_ma[4];
    assign mem_write   = ctl_ma[3];
    assign size        = ctl_ma[2:1];
    assign is_unsigned = ctl_ma[0];
    assign mem_to_reg  = ctl_wb[1];
    assign reg_write   = ctl_wb[0];

    logic is_byte, is_half, is_word;
    assign is_byte = (size == 2'b00);
    assign is_half = (size == 2'b01);
    assign is_word = ~is_byte & ~is_half;   // 10 is treated as word

    logic access, misaligned;
    assign access     = mem_read | mem_write;
    assign misaligned = access & ((is_half & i_result[0]) |
                                  (is_word & (i_result[1:0] != 2'b00)));

    // Reset gates the request so it drops the instant reset asserts,
    // even while upstream still presents a memory instruction.
    assign o_dmem_req = i_reset & (((state == S_IDLE) & access & ~misaligned) |
                                   (state == S_WAIT));
    assign o_dmem_we  = o_dmem_req & mem_write & ~mem_read;
    assign o_stall    = o_dmem_req & ~i_dmem_ack;
    assign o_dmem_addr = {i_result[NB_DATA-1:2], 2'b00};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (access & ~misaligned & ~i_dmem_ack) state_next = S_WAIT;
            S_WAIT: if (i_dmem_ack) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Little-endian store lane placement.
    always_comb begin
        o_dmem_be    = 4'b1111;
        o_dmem_wdata = i_w_data_mem;
        if (is_byte) begin
            o_dmem_be    = 4'b0001 << i_result[1:0];
            o_dmem_wdata = {4{i_w_data_mem[7:0]}};
        end else if (is_half) begin
            o_dmem_be    = i_result[1] ? 4'b1100 : 4'b0011;
            o_dmem_wdata = {2{i_w_data_mem[15:0]}};
        end
    end

    // Load lane extraction and extension.
    logic [7:0]         lb;
    logic [15:0]        lh;
    logic [NB_DATA-1:0] ext_data, load_data;

    always_comb begin
        case (i_result[1:0])
            2'b00:   lb = i_dmem_rdata[7:0];
            2'b01:   lb = i_dmem_rdata[15:8];
            2'b10:   lb = i_dmem_rdata[23:16];
            default: lb = i_dmem_rdata[31:24];
        endcase
        lh = i_result[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        if (is_byte)
            ext_data = is_unsigned ? {{(NB_DATA-8){1'b0}}, lb}
                                   : {{(NB_DATA-8){lb[7]}}, lb};
        else if (is_half)
            ext_data = is_unsigned ? {{(NB_DATA-16){1'b0}}, lh}
                                   : {{(NB_DATA-16){lh[15]}}, lh};
        else
            ext_data = i_dmem_rdata;
    end

    // Only a live, aligned load samples the bus; anything else (including a
    // stray ack after reset) contributes zero.
    assign load_data = (mem_read & ~misaligned) ? ext_data : '0;

    assign o_ex_rd_data = mem_to_reg ? load_data : i_result;
    assign o_ex_rd_num  = i_rd_num;
    assign o_ex_ctl_rw  = reg_write & ~o_stall & ~misaligned &
                          (i_rd_num != '0);

    // MA/WB boundary: bubble while stalled, otherwise advance.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_control_wb <= '0;
            o_read_data  <= '0;
            o_alu_result <= '0;
            o_rd_num     <= '0;
            o_misaligned <= 1'b0;
        end else if (o_stall) begin
            o_control_wb <= '0;
            o_misaligned <= 1'b0;
        end else begin
            o_control_wb <= {mem_to_reg, reg_write & ~misaligned};
            o_read_data  <= load_data;
            o_alu_result <= i_result;
            o_rd_num     <= i_rd_num;
            o_misaligned <= misaligned;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// ---------------------------------------------------------------------------
// tb_memory_access -- directed self-checking bench for memory_access.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// a further 1-2 units later. Expected WB results are queued when each
// access is issued and popped after the edge that retires it.
// ---------------------------------------------------------------------------
module tb_memory_access;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [6:0]  i_control_ma_wb;
    logic [31:0] i_result, i_w_data_mem, i_dmem_rdata;
    logic [4:0]  i_rd_num;
    logic        i_dmem_ack;
    logic        o_dmem_req, o_dmem_we, o_stall, o_misaligned, o_ex_ctl_rw;
    logic [31:0] o_dmem_addr, o_dmem_wdata, o_read_data, o_alu_result, o_ex_rd_data;
    logic [3:0]  o_dmem_be;
    logic [1:0]  o_control_wb;
    logic [4:0]  o_rd_num, o_ex_rd_num;

    always #5 i_clk = ~i_clk;

    memory_access dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_control_ma_wb(i_control_ma_wb),
        .i_result(i_result), .i_w_data_mem(i_w_data_mem), .i_rd_num(i_rd_num),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be), .i_dmem_ack(i_dmem_ack),
        .i_dmem_rdata(i_dmem_rdata), .o_stall(o_stall), .o_misaligned(o_misaligned),
        .o_control_wb(o_control_wb), .o_read_data(o_read_data),
        .o_alu_result(o_alu_result), .o_rd_num(o_rd_num),
        .o_ex_rd_data(o_ex_rd_data), .o_ex_rd_num(o_ex_rd_num),
        .o_ex_ctl_rw(o_ex_ctl_rw)
    );

    typedef struct {
        logic [1:0]  ctl;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        i_control_ma_wb = '0;
        i_result        = '0;
        i_w_data_mem    = '0;
        i_rd_num        = '0;
        i_dmem_ack      = 1'b0;
        i_dmem_rdata    = '0;
    endtask

    // Issue one memory access at posedge+1, ack after nwait cycles, and
    // compare the retired WB registers against the queued expectation.
    task automatic access_tx(input logic [6:0] ctl, input logic [31:0] res,
                             input logic [31:0] wd, input logic [4:0] rd,
                             input int nwait, input logic [31:0] rdata,
                             input logic exp_we, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata,
                             input logic [1:0] exp_ctl, input logic [31:0] exp_rdata);
        exp_t e;
        sb.push_back('{ctl: exp_ctl, rdata: exp_rdata, alu: res, rd: rd});
        i_control_ma_wb = ctl;
        i_result        = res;
        i_w_data_mem    = wd;
        i_rd_num        = rd;
        i_dmem_ack      = (nwait == 0);
        i_dmem_rdata    = (nwait == 0) ? rdata : 32'h5A5A_5A5A;
        #1;
        chk("req", {31'b0, o_dmem_req}, 32'd1);
        chk("we", {31'b0, o_dmem_we}, {31'b0, exp_we});
        chk("addr", o_dmem_addr, {res[31:2], 2'b00});
        if (exp_we) begin
            chk("be", {28'b0, o_dmem_be}, {28'b0, exp_be});
            chk("wdata", o_dmem_wdata, exp_wdata);
        end
        for (int i = 0; i < nwait; i++) begin
            chk("stall_wait", {31'b0, o_stall}, 32'd1);
            @(posedge i_clk); #1;
            chk("bubble", {30'b0, o_control_wb}, 32'd0);
            chk("req_hold", {31'b0, o_dmem_req}, 32'd1);
        end
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = rdata;
        #1;
        chk("stall_ack", {31'b0, o_stall}, 32'd0);
        @(posedge i_clk); #1;
        e = sb.pop_front();
        chk("wb_ctl", {30'b0, o_control_wb}, {30'b0, e.ctl});
        chk("wb_rdata", o_read_data, e.rdata);
        chk("wb_alu", o_alu_result, e.alu);
        chk("wb_rd", {27'b0, o_rd_num}, {27'b0, e.rd});
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        i_reset = 1'b1;
        #2 i_reset = 1'b0;
        #1;
        chk("rst_ctl", {30'b0, o_control_wb}, 32'd0);
        chk("rst_rdata", o_read_data, 32'd0);
        chk("rst_alu", o_alu_result, 32'd0);
        chk("rst_rd", {27'b0, o_rd_num}, 32'd0);
        chk("rst_mis", {31'b0, o_misaligned}, 32'd0);
        chk("rst_req", {31'b0, o_dmem_req}, 32'd0);
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b1;

        // Word load, zero-wait
        access_tx(7'b1011011, 32'h100, 32'h0, 5'd3, 0, 32'hDEADBEEF,
                  1'b0, 4'h0, 32'h0, 2'b11, 32'hDEADBEEF);
        // Signed byte load, three wait cycles
        access_tx(7'b1000011, 32'h103, 32'h0, 5'd4, 3, 32'h80FFFFFF,
                  1'b0, 4'h0, 32'h0, 2'b11, 32'hFFFFFF80);
        // Unsigned byte, lane 1
        access_tx(7'b1000111, 32'h101, 32'h0, 5'd6, 0, 32'h00009A00,
                  1'b0, 4'h0, 32'h0, 2'b11, 32'h0000009A);
        // Unsigned half, upper lane
        access_tx(7'b1001111, 32'h102, 32'h0, 5'd8, 1, 32'h80011234,
                  1'b0, 4'h0, 32'h0, 2'b11, 32'h00008001);
        // Signed half, lower lane
        access_tx(7'b1001011, 32'h100, 32'h0, 5'd9, 0, 32'h1234F00D,
                  1'b0, 4'h0, 32'h0, 2'b11, 32'hFFFFF00D);
        // Half store, upper lane
        access_tx(7'b0101000, 32'h102, 32'h0000ABCD, 5'd0, 1, 32'h0,
                  1'b1, 4'b1100, 32'hABCDABCD, 2'b00, 32'h0);
        // Byte store, lane 1
        access_tx(7'b0100000, 32'h101, 32'h12345678, 5'd0, 0, 32'h0,
                  1'b1, 4'b0010, 32'h78787878, 2'b00, 32'h0);
        // Word store, two waits
        access_tx(7'b0111000, 32'h104, 32'h89ABCDEF, 5'd0, 2, 32'h0,
                  1'b1, 4'b1111, 32'h89ABCDEF, 2'b00, 32'h0);
        // Read and write both set: read wins, no write
        access_tx(7'b1111011, 32'h108, 32'hFFFFFFFF, 5'd10, 0, 32'h11223344,
                  1'b0, 4'h0, 32'h0, 2'b11, 32'h11223344);

        // Misaligned word load
        i_control_ma_wb = 7'b1011011; i_result = 32'h101; i_rd_num = 5'd7;
        #1;
        chk("mis_req", {31'b0, o_dmem_req}, 32'd0);
        chk("mis_stall", {31'b0, o_stall}, 32'd0);
        chk("mis_fwd_rw", {31'b0, o_ex_ctl_rw}, 32'd0);
        @(posedge i_clk); #1;
        chk("mis_pulse", {31'b0, o_misaligned}, 32'd1);
        chk("mis_rw", {31'b0, o_control_wb[0]}, 32'd0);
        idle_inputs();
        @(posedge i_clk); #1;
        chk("mis_pulse_end", {31'b0, o_misaligned}, 32'd0);

        // Misaligned half
        i_control_ma_wb = 7'b1001011; i_result = 32'h201;
        #1 chk("mis_half_req", {31'b0, o_dmem_req}, 32'd0);
        idle_inputs();
        @(posedge i_clk); #1;

        // ALU op forwarding
        i_control_ma_wb = 7'b0000001; i_result = 32'd7; i_rd_num = 5'd5;
        #1;
        chk("alu_fwd_data", o_ex_rd_data, 32'd7);
        chk("alu_fwd_rw", {31'b0, o_ex_ctl_rw}, 32'd1);
        chk("alu_fwd_rd", {27'b0, o_ex_rd_num}, 32'd5);
        chk("alu_req", {31'b0, o_dmem_req}, 32'd0);
        i_rd_num = 5'd0;
        #1 chk("alu_fwd_rw_r0", {31'b0, o_ex_ctl_rw}, 32'd0);
        @(posedge i_clk); #1;
        chk("alu_wb_ctl", {30'b0, o_control_wb}, 32'd1);
        chk("alu_wb_res", o_alu_result, 32'd7);
        idle_inputs();

        // Ack with nothing pending
        i_dmem_ack = 1'b1; i_dmem_rdata = 32'hFFFF0000;
        #1;
        chk("spur_req", {31'b0, o_dmem_req}, 32'd0);
        chk("spur_stall", {31'b0, o_stall}, 32'd0);
        @(posedge i_clk); #1;
        i_dmem_ack = 1'b0;
        #1 chk("spur_req_after", {31'b0, o_dmem_req}, 32'd0);
        @(posedge i_clk); #1;

        // Reset mid-WAIT, then a late ack
        i_control_ma_wb = 7'b1000011; i_result = 32'h200; i_rd_num = 5'd12;
        @(posedge i_clk); #1;
        #1 chk("wait_req", {31'b0, o_dmem_req}, 32'd1);
        i_reset = 1'b0;
        #1;
        chk("rst_mid_req", {31'b0, o_dmem_req}, 32'd0);
        chk("rst_mid_stall", {31'b0, o_stall}, 32'd0);
        chk("rst_mid_ctl", {30'b0, o_control_wb}, 32'd0);
        chk("rst_mid_alu", o_alu_result, 32'd0);
        chk("rst_mid_rdata", o_read_data, 32'd0);
        idle_inputs();
        @(posedge i_clk); #1 i_reset = 1'b1;
        #1;
        i_dmem_ack = 1'b1; i_dmem_rdata = 32'hCAFEF00D;
        #1;
        chk("late_ack_req", {31'b0, o_dmem_req}, 32'd0);
        chk("late_ack_stall", {31'b0, o_stall}, 32'd0);
        @(posedge i_clk); #1;
        chk("late_ack_rdata", o_read_data, 32'd0);
        chk("late_ack_ctl", {30'b0, o_control_wb}, 32'd0);
        idle_inputs();
        @(posedge i_clk); #1;

        // Recovery after reset
        access_tx(7'b1011011, 32'h300, 32'h0, 5'd2, 1, 32'h0BADF00D,
                  1'b0, 4'h0, 32'h0, 2'b11, 32'h0BADF00D);

        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
